moore_sel_fsm: RTL and testbench
================================

# moore_sel_fsm

Parametrised Moore-style channel selector: an N-state machine whose output is the W-bit data word of the channel matching the current state. The state steps up or down on an advance strobe and skips channels masked off. It wraps or saturates at the ends, and can be loaded directly. It is the N-channel, bidirectional, maskable successor of the two-state toggle selector and sits between control logic and a set of data sources as a stateful output mux.

## Interface
- W, default 8: data width per channel.
- N, default 4: number of states/channels, N >= 2.
- SAT, default 0: 0 = wrap at the ends, 1 = saturate at the ends.
- SW, derived, $clog2(N): width of the state index.

Ports, listed as name, direction, width, meaning:
- clk, in, 1: clock, all logic on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- adv, in, 1: advance strobe, moves one enabled step per cycle while high.
- dir, in, 1: step direction, 0 = up (increasing index), 1 = down.
- ld, in, 1: load request.
- ld_state, in, SW: target index for a load.
- en_mask, in, N: bit k = 1 means channel k is eligible as an advance destination.
- din, in, N*W: channel k occupies din[k*W +: W].
- y, out, W: Moore output, equal to din slice[state].
- state, out, SW: current state index.
- wrap, out, 1: registered one-cycle pulse, the last advance crossed the end boundary.
- all_masked, out, 1: combinational, high when en_mask == 0.

## Operation
- State register priority on each edge: rst, then ld, then adv, then hold.
- **rst:** state = 0 and wrap = 0.
- **ld with ld_state < N:** state = ld_state. en_mask is ignored for loads. wrap = 0.
- **ld with ld_state >= N:** request ignored. state holds, wrap = 0, and adv is NOT evaluated that cycle.
- **adv, up direction:** search indices state+1, state+2, … for the first bit set in en_mask.
  - SAT=0: the search wraps modulo N.
  - SAT=1: the search stops at N-1. If no enabled index is found, state holds.
- **adv, down direction:** the mirror of the up case. With SAT=1 the search stops at 0.
- **All channels masked:** if all_masked is high, adv holds the state.
- **Only the current channel enabled:** with SAT=0, the search returns the current index, so state is unchanged and wrap = 0.
- **wrap:** set in the cycle after an advance where the new index is below the old one (up) or above it (down). Otherwise wrap is 0. It is never set when SAT=1.
- **Output:** y = din[state*W +: W]. It is purely combinational from state and din, with no dependency on adv, dir or ld. This is Moore behaviour.
- **Illegal state:** state never exceeds N-1. If N is not a power of two, an out-of-range state (not reachable) is forced to 0 on the next edge.

## Timing
- Reset values: state = 0, wrap = 0, y = din[0 +: W], all_masked = (en_mask == 0).
- Latency: adv or ld sampled at edge t takes effect in state and y after edge t, with zero added latency.
- Change in din: reaches y in the same cycle.
- Continuous adv: one enabled step per clock.
- ld and adv in the same cycle: ld wins.
- rst asserted mid-sequence: it overrides everything on that edge, and a pending wrap pulse is cleared.
- en_mask change: sampled only in the cycle adv is evaluated. There are no hazards on masked-off channels.

## Structure
- **Package moore_pkg:** holds the SAT mode constants (MODE_WRAP = 0, MODE_SAT = 1) and the direction constants (DIR_UP = 0, DIR_DOWN = 1).
- **Sub-module moore_next_idx (N, SAT):** combinational. Inputs are cur, dir and mask. Outputs are nxt, found and crossed, produced by a rotating priority search. The top level instantiates it once and holds only the state and wrap registers and the output mux.

## Test plan
- **Reset and mux:** W=8, N=4, din = {8'h44, 8'h33, 8'h22, 8'h11}, rst for 2 cycles. Required: state = 0, y = 8'h11, wrap = 0. Changing din[0] to 8'hAA gives y = 8'hAA in the same cycle.
- **Up with wrap:** en_mask = 4'b1111, dir = 0, adv held for 5 cycles. Required: state goes 1, 2, 3, 0, 1. wrap is high exactly in the cycle after 3 -> 0. y tracks the matching channel.
- **Masked skip, down:** en_mask = 4'b1010, state = 3, dir = 1, adv held for 3 cycles. Required: state goes 1, 3, 1. wrap pulses after 1 -> 3.
- **Saturate:** SAT=1, en_mask = 4'b0111, state = 2, dir = 0, adv held for 3 cycles. Required: state stays 2 and wrap stays 0. Then dir = 1 for 3 cycles gives 1, 0, 0.
- **Load priority and illegal load:** ld = 1 and adv = 1 with ld_state = 2 and en_mask = 4'b0001. Required: state = 2. Then ld with ld_state = 5 on a non-power-of-2 build (N = 5 is legal, so use N=5 and ld_state = 6). Required: state unchanged and adv not evaluated that cycle.
- **Degenerate masks and reset mid-run:** en_mask = 0 with adv. Required: state holds and all_masked = 1. en_mask = 4'b0100 with state = 2 and adv. Required: state = 2 and wrap = 0. Asserting rst during a wrap cycle gives state = 0 and wrap = 0 on the next edge.

Source files
------------

// File: rtl/moore_pkg.sv
// Shared constants and types for the Moore channel selector.
package moore_pkg;

    // End-of-range behaviour of the index search
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Step direction encoding on the dir input
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Action chosen for the state register on the coming edge
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_STEP = 2'd2,
        ACT_FIX  = 2'd3
    } act_e;

endpackage

// File: rtl/moore_next_idx.sv
// Rotating priority search: from index cur, find the nearest enabled channel
// in the requested direction, either wrapping modulo N or stopping at the end.
module moore_next_idx
    import moore_pkg::*;
#(
    parameter int   N   = 4,
    parameter logic SAT = MODE_WRAP,
    localparam int  SW  = $clog2(N)
) (
    input  logic [SW-1:0] cur,
    input  logic          dir,
    input  logic [N-1:0]  mask,
    output logic [SW-1:0] nxt,
    output logic          found,
    output logic          crossed
);

    int            cand_s;
    logic [SW-1:0] idx_s;
    logic          over_s;
    logic          hit_s;

    // Walk distances 1..N and keep the first enabled hit; distance N lands on cur
    always_comb begin
        nxt     = cur;
        found   = 1'b0;
        crossed = 1'b0;
        cand_s  = 0;
        idx_s   = cur;
        over_s  = 1'b0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s  = (dir == DIR_DOWN) ? (int'(cur) - k) : (int'(cur) + k);
            over_s  = (cand_s < 0) || (cand_s >= N);
            cand_s  = (cand_s < 0)  ? (cand_s + N) :
                      (cand_s >= N) ? (cand_s - N) : cand_s;
            idx_s   = cand_s[SW-1:0];
            // In saturate mode positions past the end are never candidates
            hit_s   = !found && !((SAT == MODE_SAT) && over_s) && mask[idx_s];
            nxt     = hit_s ? idx_s : nxt;
            // Landing back on cur after a full lap is not a boundary crossing
            crossed = hit_s ? (over_s && (idx_s != cur)) : crossed;
            found   = found | hit_s;
        end
    end

endmodule

// File: rtl/moore_sel_fsm.sv
// Moore channel selector: state index register with load/advance, a wrap
// pulse register, and an output mux selecting din slice[state].
module moore_sel_fsm
    import moore_pkg::*;
#(
    parameter int   W   = 8,
    parameter int   N   = 4,
    parameter logic SAT = MODE_WRAP,
    localparam int  SW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic            dir,
    input  logic            ld,
    input  logic [SW-1:0]   ld_state,
    input  logic [N-1:0]    en_mask,
    input  logic [N*W-1:0]  din,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   state,
    output logic            wrap,
    output logic            all_masked
);

    logic [SW-1:0] state_r;
    logic [SW-1:0] state_nxt_s;
    logic          wrap_r;
    logic          wrap_nxt_s;
    logic [SW-1:0] srch_nxt_s;
    logic          srch_found_s;
    logic          srch_crossed_s;
    logic          state_bad_s;
    logic          ld_ok_s;
    act_e          act_s;

    moore_next_idx #(
        .N   (N),
        .SAT (SAT)
    ) u_next_idx (
        .cur     (state_r),
        .dir     (dir),
        .mask    (en_mask),
        .nxt     (srch_nxt_s),
        .found   (srch_found_s),
        .crossed (srch_crossed_s)
    );

    // Decide the register action: recover illegal state, then load, then advance
    always_comb begin
        state_bad_s = (int'(state_r) >= N);
        ld_ok_s     = (int'(ld_state) < N);
        if (state_bad_s) begin
            act_s = ACT_FIX;
        end else if (ld) begin
            // An out-of-range load swallows the cycle: adv is not looked at
            act_s = ld_ok_s ? ACT_LOAD : ACT_HOLD;
        end else if (adv && srch_found_s) begin
            act_s = ACT_STEP;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next state and next wrap pulse for the chosen action
    always_comb begin
        state_nxt_s = state_r;
        wrap_nxt_s  = 1'b0;
        case (act_s)
            ACT_LOAD: begin
                state_nxt_s = ld_state;
                wrap_nxt_s  = 1'b0;
            end
            ACT_STEP: begin
                state_nxt_s = srch_nxt_s;
                wrap_nxt_s  = srch_crossed_s;
            end
            ACT_FIX: begin
                state_nxt_s = {SW{1'b0}};
                wrap_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = state_r;
                wrap_nxt_s  = 1'b0;
            end
        endcase
    end

    // State index and wrap pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= {SW{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    // Moore output mux; an unreachable out-of-range index shows channel 0
    always_comb begin
        y = din[W-1:0];
        for (int k = 0; k < N; k++) begin
            y = (int'(state_r) == k) ? din[k*W +: W] : y;
        end
    end

    // Mask status flag, independent of the state register
    always_comb begin
        all_masked = (en_mask == {N{1'b0}});
    end

    assign state = state_r;
    assign wrap  = wrap_r;

endmodule

// File: tb/tb_moore_sel_fsm.sv
// Self-checking bench: three builds (N=4 wrap, N=4 saturate, N=5 wrap) share
// control inputs and are compared against a distance-based reference model.
module tb_moore_sel_fsm;
    import moore_pkg::*;

    logic        clk = 1'b0;
    logic        rst, adv, dir, ld;
    logic [1:0]  lds4;
    logic [2:0]  lds5;
    logic [3:0]  mask4;
    logic [4:0]  mask5;
    logic [31:0] din4;
    logic [39:0] din5;

    logic [7:0]  y_w, y_s, y_5;
    logic [1:0]  st_w, st_s;
    logic [2:0]  st_5;
    logic        wr_w, wr_s, wr_5, am_w, am_s, am_5;

    int n_checks = 0;
    int n_errors = 0;

    int mw = 0, ms = 0, m5 = 0;
    bit ew = 1'b0, es = 1'b0, e5 = 1'b0;

    always #5 clk = ~clk;

    moore_sel_fsm #(.W(8), .N(4), .SAT(MODE_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_state(lds4),
        .en_mask(mask4), .din(din4), .y(y_w), .state(st_w), .wrap(wr_w),
        .all_masked(am_w)
    );

    moore_sel_fsm #(.W(8), .N(4), .SAT(MODE_SAT)) u_sat (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_state(lds4),
        .en_mask(mask4), .din(din4), .y(y_s), .state(st_s), .wrap(wr_s),
        .all_masked(am_s)
    );

    moore_sel_fsm #(.W(8), .N(5), .SAT(MODE_WRAP)) u_n5 (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_state(lds5),
        .en_mask(mask5), .din(din5), .y(y_5), .state(st_5), .wrap(wr_5),
        .all_masked(am_5)
    );

    // Reference: try each distance d in turn, nearest enabled channel wins
    function automatic void ref_step(input int cur, input int n, input bit sat,
                                     input bit r, input bit l, input int lds,
                                     input bit a, input bit dn, input int mask,
                                     output int nxt, output bit wr);
        bit done;
        int pos;
        nxt  = cur;
        wr   = 1'b0;
        done = 1'b0;
        if (r) begin
            nxt = 0;
        end else if (l) begin
            if (lds < n) nxt = lds;
        end else if (a) begin
            for (int d = 1; d <= n; d++) begin
                pos = dn ? cur - d : cur + d;
                if (!done && !(sat && (pos < 0 || pos >= n))) begin
                    pos = (pos + n) % n;
                    if (((mask >> pos) & 1) != 0) begin
                        nxt  = pos;
                        wr   = dn ? (pos > cur) : (pos < cur);
                        done = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic int slice4(input int i);
        return int'((din4 >> (i * 8)) & 32'hFF);
    endfunction

    function automatic int slice5(input int i);
        return int'((din5 >> (i * 8)) & 40'hFF);
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("w.state", int'(st_w), mw);
        check_eq("w.y",     int'(y_w),  slice4(mw));
        check_eq("w.wrap",  int'(wr_w), int'(ew));
        check_eq("w.allm",  int'(am_w), int'(mask4 == 4'd0));
        check_eq("s.state", int'(st_s), ms);
        check_eq("s.y",     int'(y_s),  slice4(ms));
        check_eq("s.wrap",  int'(wr_s), int'(es));
        check_eq("s.allm",  int'(am_s), int'(mask4 == 4'd0));
        check_eq("n5.state", int'(st_5), m5);
        check_eq("n5.y",     int'(y_5),  slice5(m5));
        check_eq("n5.wrap",  int'(wr_5), int'(e5));
        check_eq("n5.allm",  int'(am_5), int'(mask5 == 5'd0));
    endtask

    // Predict, clock once, then sample 1 time unit after the edge
    task automatic step();
        int nw, ns, nn;
        bit xw, xs, xn;
        ref_step(mw, 4, 1'b0, rst, ld, int'(lds4), adv, dir, int'(mask4), nw, xw);
        ref_step(ms, 4, 1'b1, rst, ld, int'(lds4), adv, dir, int'(mask4), ns, xs);
        ref_step(m5, 5, 1'b0, rst, ld, int'(lds5), adv, dir, int'(mask5), nn, xn);
        @(posedge clk);
        #1;
        mw = nw; ew = xw;
        ms = ns; es = xs;
        m5 = nn; e5 = xn;
        check_all();
    endtask

    initial begin
        int exp_up[5];
        int exp_upw[5];
        int exp_dn[3];
        int exp_dnw[3];
        int exp_sd[3];
        exp_up  = '{1, 2, 3, 0, 1};
        exp_upw = '{0, 0, 0, 1, 0};
        exp_dn  = '{1, 3, 1};
        exp_dnw = '{0, 1, 0};
        exp_sd  = '{1, 0, 0};

        rst = 1'b1; adv = 1'b0; dir = DIR_UP; ld = 1'b0;
        lds4 = 2'd0; lds5 = 3'd0; mask4 = 4'hF; mask5 = 5'h1F;
        din4 = 32'h44332211; din5 = 40'h5544332211;

        // Reset and combinational mux
        repeat (2) step();
        check_eq("rst.state", int'(st_w), 0);
        check_eq("rst.y",     int'(y_w),  8'h11);
        check_eq("rst.wrap",  int'(wr_w), 0);
        din4[7:0] = 8'hAA;
        #1;
        check_eq("mux.comb", int'(y_w), 8'hAA);
        din4[7:0] = 8'h11;
        rst = 1'b0;

        // Up with wrap
        mask4 = 4'b1111; dir = DIR_UP; adv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("up.state", int'(st_w), exp_up[i]);
            check_eq("up.wrap",  int'(wr_w), exp_upw[i]);
        end

        // Masked skip, down
        adv = 1'b0; ld = 1'b1; lds4 = 2'd3; lds5 = 3'd3;
        step();
        ld = 1'b0; mask4 = 4'b1010; dir = DIR_DOWN; adv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("dn.state", int'(st_w), exp_dn[i]);
            check_eq("dn.wrap",  int'(wr_w), exp_dnw[i]);
        end

        // Saturate
        adv = 1'b0; ld = 1'b1; lds4 = 2'd2;
        step();
        ld = 1'b0; mask4 = 4'b0111; dir = DIR_UP; adv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sat.hold",  int'(st_s), 2);
            check_eq("sat.wrap",  int'(wr_s), 0);
        end
        dir = DIR_DOWN;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sat.dn",    int'(st_s), exp_sd[i]);
            check_eq("sat.dwrap", int'(wr_s), 0);
        end

        // Load beats advance; out-of-range load ignored and adv skipped
        ld = 1'b1; adv = 1'b1; dir = DIR_UP; lds4 = 2'd2; lds5 = 3'd2;
        mask4 = 4'b0001; mask5 = 5'h1F;
        step();
        check_eq("ld.prio",   int'(st_w), 2);
        check_eq("ld.prio5",  int'(st_5), 2);
        lds4 = 2'd1; lds5 = 3'd6;
        step();
        check_eq("ld.illegal", int'(st_5), 2);

        // Degenerate masks
        ld = 1'b0; mask4 = 4'b0000; adv = 1'b1;
        step();
        check_eq("mask0.state", int'(st_w), 1);
        check_eq("mask0.allm",  int'(am_w), 1);
        ld = 1'b1; lds4 = 2'd2; adv = 1'b0;
        step();
        ld = 1'b0; mask4 = 4'b0100; adv = 1'b1;
        step();
        check_eq("self.state", int'(st_w), 2);
        check_eq("self.wrap",  int'(wr_w), 0);

        // Reset mid-run
        mask4 = 4'hF; dir = DIR_UP; ld = 1'b1; lds4 = 2'd3; adv = 1'b0;
        step();
        ld = 1'b0; adv = 1'b1;
        step();
        check_eq("pre.wrap", int'(wr_w), 1);
        rst = 1'b1;
        step();
        check_eq("rstw.state", int'(st_w), 0);
        check_eq("rstw.wrap",  int'(wr_w), 0);
        rst = 1'b0; ld = 1'b1; lds4 = 2'd3; adv = 1'b0;
        step();
        ld = 1'b0; mask4 = 4'b0010; adv = 1'b1; rst = 1'b1;
        step();
        check_eq("rsta.state", int'(st_w), 0);
        check_eq("rsta.wrap",  int'(wr_w), 0);
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(31, 0) == 0);
            ld    = ($urandom_range(7, 0) == 0);
            adv   = ($urandom_range(3, 0) != 0);
            dir   = 1'($urandom);
            lds4  = 2'($urandom);
            lds5  = 3'($urandom);
            mask4 = 4'($urandom);
            mask5 = 5'($urandom);
            if ($urandom_range(15, 0) == 0) begin
                din4 = $urandom;
                din5 = {8'($urandom), $urandom};
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
